// File: rtl/bitwise_defs.sv
// Shared encodings for the sliced bitwise logic unit.
// Holds the operation codes and FSM state encodings.
package bitwise_defs;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/bitwise_slice.sv
// One SLICE-bit lane of the bitwise unit: applies op to a/b
// and returns the slice result (res) and its population count (pop).
module bitwise_slice
    import bitwise_defs::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0]           a,
    input  logic [SLICE-1:0]           b,
    input  op_e                        op,
    output logic [SLICE-1:0]           res,
    output logic [$clog2(SLICE+1)-1:0] pop
);

    localparam int PW = $clog2(SLICE + 1);

    always_comb begin
        res = '0;
        unique case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < SLICE; i++) begin
            pop = pop + PW'(res[i]);
        end
    end

endmodule

// File: rtl/bitwise_seq.sv
// Multi-cycle AND/OR/XOR/NOR unit, SLICE bits per cycle, LSB first.
// Ports: clock, reset_n, start/op/data_a/data_b in; busy, result_rdy,
// result, zero, popcount out (outputs held until the next completion).
module bitwise_seq
    import bitwise_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           data_a,
    input  logic [WIDTH-1:0]           data_b,
    output logic                       busy,
    output logic                       result_rdy,
    output logic [WIDTH-1:0]           result,
    output logic                       zero,
    output logic [$clog2(WIDTH+1)-1:0] popcount
);

    localparam int N   = WIDTH / SLICE;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW  = $clog2(WIDTH + 1);
    localparam int SPW = $clog2(SLICE + 1);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    op_e               op_q, op_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [PW-1:0]     pop_q, pop_d;
    logic              zero_q, zero_d;

    logic [SLICE-1:0]  s_a, s_b, s_res;
    logic [SPW-1:0]    s_pop;
    logic              last;

    assign s_a  = a_q[k_q*SLICE +: SLICE];
    assign s_b  = b_q[k_q*SLICE +: SLICE];
    assign last = (k_q == KW'(N - 1));

    bitwise_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a   (s_a),
        .b   (s_b),
        .op  (op_q),
        .res (s_res),
        .pop (s_pop)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        work_d   = work_q;
        acc_d    = acc_q;
        result_d = result_q;
        pop_d    = pop_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // A start in DONE chains straight into the next RUN.
                if (start) begin
                    state_d = RUN;
                    a_d     = data_a;
                    b_d     = data_b;
                    op_d    = op_e'(op);
                    k_d     = '0;
                    work_d  = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                work_d[k_q*SLICE +: SLICE] = s_res;
                acc_d = acc_q + PW'(s_pop);
                k_d   = k_q + KW'(1);
                // Final slice: publish the merged word on DONE entry.
                if (last) begin
                    state_d  = DONE;
                    result_d = work_d;
                    pop_d    = acc_d;
                    zero_d   = (acc_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            work_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            pop_q    <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            pop_q    <= pop_d;
            zero_q   <= zero_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign result_rdy = (state_q == DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign popcount   = pop_q;

endmodule

// File: tb/tb_bitwise_seq.sv
// Directed and random checks for bitwise_seq.
// Covers a 32/8 instance and a 16/16 single-slice instance.
module tb_bitwise_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, rdy32, zero32;
    logic [31:0] res32;
    logic [5:0]  pop32;

    logic        start16 = 1'b0;
    logic [1:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, rdy16, zero16;
    logic [15:0] res16;
    logic [4:0]  pop16;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bitwise_seq #(.WIDTH(32), .SLICE(8)) u_dut (
        .clock      (clk),
        .reset_n    (rst_n),
        .start      (start32),
        .op         (op32),
        .data_a     (a32),
        .data_b     (b32),
        .busy       (busy32),
        .result_rdy (rdy32),
        .result     (res32),
        .zero       (zero32),
        .popcount   (pop32)
    );

    bitwise_seq #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clock      (clk),
        .reset_n    (rst_n),
        .start      (start16),
        .op         (op16),
        .data_a     (a16),
        .data_b     (b16),
        .busy       (busy16),
        .result_rdy (rdy16),
        .result     (res16),
        .zero       (zero16),
        .popcount   (pop16)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input logic [1:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int cyc);
        op32 = o;
        a32 = a;
        b32 = b;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        cyc = 0;
        while (!rdy32 && cyc < 20) begin
            chk("busy32_run", busy32, 1);
            tick();
            cyc++;
        end
        chk("rdy32_seen", rdy32, 1);
        chk("busy32_done", busy32, 0);
    endtask

    task automatic run16(input logic [1:0] o,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         output int cyc);
        op16 = o;
        a16 = a;
        b16 = b;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        cyc = 0;
        while (!rdy16 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rdy16_seen", rdy16, 1);
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [31:0] cap;
        logic [31:0] e32;
        logic [15:0] e16;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        tick();
        tick();
        chk("rst_result", res32, 0);
        chk("rst_pop", pop32, 0);
        chk("rst_zero", zero32, 1);
        chk("rst_busy", busy32, 0);
        chk("rst_rdy", rdy32, 0);
        chk("rst_zero16", zero16, 1);
        rst_n = 1'b1;
        tick();

        run32(2'b00, 32'hF0F01234, 32'hFF00FFFF, cyc);
        chk("and_lat", cyc, 4);
        chk("and_res", res32, 32'hF0001234);
        chk("and_pop", pop32, 9);
        chk("and_zero", zero32, 0);
        tick();
        chk("and_rdy_pulse", rdy32, 0);
        chk("and_hold", res32, 32'hF0001234);

        run32(2'b10, 32'hDEADBEEF, 32'hDEADBEEF, cyc);
        chk("xor_res", res32, 0);
        chk("xor_zero", zero32, 1);
        chk("xor_pop", pop32, 0);
        tick();

        run32(2'b11, 32'h0, 32'h0, cyc);
        chk("nor_res", res32, 32'hFFFFFFFF);
        chk("nor_pop", pop32, 32);
        chk("nor_zero", zero32, 0);
        tick();

        op32 = 2'b01;
        a32 = 32'h0000000F;
        b32 = 32'h000000F0;
        start32 = 1'b1;
        tick();
        a32 = 32'hFFFFFFFF;
        tick();
        start32 = 1'b0;
        a32 = 32'h12345678;
        pulses = 0;
        cap = '0;
        for (int i = 0; i < 12; i++) begin
            if (rdy32) begin
                pulses++;
                cap = res32;
            end
            tick();
        end
        chk("lock_pulses", pulses, 1);
        chk("lock_res", cap, 32'h000000FF);
        chk("lock_pop", pop32, 8);
        chk("lock_idle", busy32, 0);

        run32(2'b10, 32'h12345678, 32'h0, cyc);
        chk("b2b_first", res32, 32'h12345678);
        chk("b2b_first_pop", pop32, 13);
        op32 = 2'b00;
        a32 = 32'hFFFF0000;
        b32 = 32'h0F0F0F0F;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        cyc = 0;
        while (!rdy32 && cyc < 20) begin
            chk("b2b_hold", res32, 32'h12345678);
            tick();
            cyc++;
        end
        chk("b2b_lat", cyc, 4);
        chk("b2b_res", res32, 32'h0F0F0000);
        chk("b2b_pop", pop32, 8);

        op32 = 2'b10;
        a32 = 32'hFFFFFFFF;
        b32 = 32'h0;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        tick();
        tick();
        chk("mid_busy", busy32, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_result", res32, 0);
        chk("mid_pop", pop32, 0);
        chk("mid_zero", zero32, 1);
        chk("mid_busy_rst", busy32, 0);
        chk("mid_rdy", rdy32, 0);
        tick();
        tick();
        chk("mid_rdy_held", rdy32, 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("mid_after_rdy", rdy32, 0);
        run32(2'b01, 32'h1, 32'h2, cyc);
        chk("post_rst_res", res32, 32'h3);
        chk("post_rst_pop", pop32, 2);
        tick();

        run16(2'b10, 16'hAAAA, 16'h5555, cyc);
        chk("p16_lat", cyc, 1);
        chk("p16_res", res16, 16'hFFFF);
        chk("p16_pop", pop16, 16);
        chk("p16_zero", zero16, 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i == 0) rb = ra;
            e32 = model(ro, ra, rb);
            run32(ro, ra, rb, cyc);
            chk("rnd32_lat", cyc, 4);
            chk("rnd32_res", res32, e32);
            chk("rnd32_pop", pop32, $countones(e32));
            chk("rnd32_zero", zero32, (e32 == 0));
        end

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            e32 = model(ro, {16'h0, ra[15:0]}, {16'h0, rb[15:0]});
            e16 = e32[15:0];
            run16(ro, ra[15:0], rb[15:0], cyc);
            chk("rnd16_lat", cyc, 1);
            chk("rnd16_res", res16, e16);
            chk("rnd16_pop", pop16, $countones(e16));
            chk("rnd16_zero", zero16, (e16 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
